mismatch_scoreboard: RTL

- Downstream checking stage for single-bit combinational problem benches.
- Consumes the reference output and the DUT output for each sample.
- Counts samples and mismatches, latches the index of the first mismatch, and flags completion, pass/fail and timeout.
- Synthesizable, cycle-accurate replacement for behavioural stats counting; one sample per clk when sample_valid is high.

---
 rtl/mismatch_scoreboard.sv | 112 +++++++++++
 1 files changed

// File: rtl/mismatch_scoreboard.sv
// Scoreboard for single-bit reference/DUT comparisons: counts samples and mismatches,
// records the first (and optionally last, with SCB_LAST_ERR_EN) mismatch index, flags done/pass/timeout.
module mismatch_scoreboard #(
  parameter int unsigned NUM_SAMPLES = 202,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             ref_z,
  input  logic             dut_z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
`ifdef SCB_LAST_ERR_EN
  ,
  output logic [CNT_W-1:0] last_err_idx,
  output logic             last_err_vld
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastSample = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] LastCycle  = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cyc_cnt_q;

  logic             accept;
  logic             mismatch;
  logic             complete;
  logic             expire;
  logic [CNT_W-1:0] err_next;

  assign accept   = (state_q == StRun) && sample_valid;
  assign mismatch = ref_z ^ dut_z;
  assign complete = accept && (sample_cnt == LastSample);
  // Completion on the last allowed cycle takes precedence over the timeout.
  assign expire   = !complete && (cyc_cnt_q == LastCycle);
  assign err_next = (accept && mismatch && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cyc_cnt_q     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
`ifdef SCB_LAST_ERR_EN
      last_err_idx  <= '0;
      last_err_vld  <= 1'b0;
`endif
    end else if (start) begin
      // Start from any state (including RUN) discards the current sample.
      state_q       <= StRun;
      cyc_cnt_q     <= '0;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
`ifdef SCB_LAST_ERR_EN
      last_err_idx  <= '0;
      last_err_vld  <= 1'b0;
`endif
    end else if (state_q == StRun) begin
      cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
      if (accept) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_next;
        if (mismatch && !first_err_vld) begin
          first_err_idx <= sample_cnt;
          first_err_vld <= 1'b1;
        end
`ifdef SCB_LAST_ERR_EN
        if (mismatch) begin
          last_err_idx <= sample_cnt;
          last_err_vld <= 1'b1;
        end
`endif
      end
      if (complete) begin
        state_q <= StDone;
        busy    <= 1'b0;
        done    <= 1'b1;
        pass    <= (err_next == '0);
      end else if (expire) begin
        state_q <= StDone;
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

endmodule
